// File: rtl/rd_codebook.sv
// rd_codebook -- reloads a packed SOM codebook from the external weight RAM.
//
// Issues N_WORDS sequential reads starting at a latched base address, one per
// cycle, and writes each returned word in place into the packed weights bus
// (word 0 in the MSBs, word N_WORDS-1 in the LSBs, matching the writer).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle load request (accepted only when idle)
//   base_addr       RAM address of word 0, latched on an accepted start
//   RAM_R_RE/_A     RAM read enable / address (registered)
//   RAM_R_D         RAM read data, valid RD_LAT cycles after RE/A
//   weights         packed codebook
//   busy            load in progress
//   done            one-cycle pulse once the last word has been captured
//   weights_valid   weights holds a complete codebook
//   chksum          (only with RD_CODEBOOK_CHKSUM_EN) sum of captured words
//
// Optional feature macro: RD_CODEBOOK_CHKSUM_EN
module rd_codebook #(
  parameter int N_WORDS = 64,
  parameter int WORD_W  = 24,
  parameter int ADDR_W  = 18,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        RAM_R_RE,
  output logic [ADDR_W-1:0]           RAM_R_A,
  input  logic [WORD_W-1:0]           RAM_R_D,
  output logic [N_WORDS*WORD_W-1:0]   weights,
  output logic                        busy,
  output logic                        done,
  output logic                        weights_valid
`ifdef RD_CODEBOOK_CHKSUM_EN
  ,
  output logic [WORD_W+5:0]           chksum
`endif
);

  localparam int IDX_W = $clog2(N_WORDS + 1);
  localparam int CHK_W = WORD_W + 6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                      r_state;
  logic [ADDR_W-1:0]           r_base;
  logic [IDX_W-1:0]            r_issue_idx;
  logic [IDX_W-1:0]            r_cap_idx;
  logic [RD_LAT-1:0]           r_vld_p;
  logic                        r_ram_re;
  logic [ADDR_W-1:0]           r_ram_a;
  logic [N_WORDS*WORD_W-1:0]   r_weights;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_weights_valid;
`ifdef RD_CODEBOOK_CHKSUM_EN
  logic [CHK_W-1:0]            r_chksum;
`endif

  assign RAM_R_RE      = r_ram_re;
  assign RAM_R_A       = r_ram_a;
  assign weights       = r_weights;
  assign busy          = r_busy;
  assign done          = r_done;
  assign weights_valid = r_weights_valid;
`ifdef RD_CODEBOOK_CHKSUM_EN
  assign chksum        = r_chksum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_base          <= '0;
      r_issue_idx     <= '0;
      r_cap_idx       <= '0;
      r_vld_p         <= '0;
      r_ram_re        <= 1'b0;
      r_ram_a         <= '0;
      r_weights       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_weights_valid <= 1'b0;
`ifdef RD_CODEBOOK_CHKSUM_EN
      r_chksum        <= '0;
`endif
    end else begin
      // Issue-strobe delay line: the registered RE travels RD_LAT stages so
      // its tail lines up with the cycle the RAM presents the matching word.
      r_vld_p[0] <= r_ram_re;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end

      // Capture stage: write the returning word in place at slot cap_idx.
      if (r_vld_p[RD_LAT-1]) begin
        for (int k = 0; k < N_WORDS; k++) begin
          if (r_cap_idx == IDX_W'(k)) begin
            r_weights[N_WORDS*WORD_W-1-k*WORD_W -: WORD_W] <= RAM_R_D;
          end
        end
        r_cap_idx <= r_cap_idx + IDX_W'(1);
`ifdef RD_CODEBOOK_CHKSUM_EN
        r_chksum  <= r_chksum + CHK_W'(RAM_R_D);
`endif
      end

      r_done <= 1'b0;

      // Control FSM; assignments here take precedence over the capture path
      // (only relevant for the counter clears on an accepted start).
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base          <= base_addr;
            r_issue_idx     <= '0;
            r_cap_idx       <= '0;
            r_busy          <= 1'b1;
            r_weights_valid <= 1'b0;
`ifdef RD_CODEBOOK_CHKSUM_EN
            r_chksum        <= '0;
`endif
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ram_re    <= 1'b1;
          r_ram_a     <= r_base + ADDR_W'(r_issue_idx);
          r_issue_idx <= r_issue_idx + IDX_W'(1);
          if (r_issue_idx == IDX_W'(N_WORDS - 1)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_ram_re <= 1'b0;
          if (r_cap_idx == IDX_W'(N_WORDS)) begin
            r_done          <= 1'b1;
            r_weights_valid <= 1'b1;
            r_busy          <= 1'b0;
            r_state         <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_codebook.sv
// Testbench for rd_codebook: RD_LAT=1 instance for most scenarios, RD_LAT=3
// instance for back-to-back loads. RAM models return a per-address pattern.
module tb_rd_codebook;

  localparam int NW = 64;
  localparam int WW = 24;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, start3;
  logic [AW-1:0]    base_addr, base3;
  logic             re0, re3;
  logic [AW-1:0]    a0, a3;
  logic [WW-1:0]    d0, d3;
  logic [NW*WW-1:0] w0, w3;
  logic             busy0, busy3, done0, done3, wv0, wv3;
`ifdef RD_CODEBOOK_CHKSUM_EN
  logic [WW+5:0]    chk0, chk3;
`endif

  int checks = 0;
  int errors = 0;
  int mode0 = 0;
  int mode3 = 0;
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q3[$];
  int re_cnt0 = 0;
  int re_cnt3 = 0;

  rd_codebook #(.N_WORDS(NW), .WORD_W(WW), .ADDR_W(AW), .RD_LAT(1)) u0 (
`ifdef RD_CODEBOOK_CHKSUM_EN
    .chksum(chk0),
`endif
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .RAM_R_RE(re0), .RAM_R_A(a0), .RAM_R_D(d0), .weights(w0),
    .busy(busy0), .done(done0), .weights_valid(wv0)
  );

  rd_codebook #(.N_WORDS(NW), .WORD_W(WW), .ADDR_W(AW), .RD_LAT(3)) u3 (
`ifdef RD_CODEBOOK_CHKSUM_EN
    .chksum(chk3),
`endif
    .clk(clk), .rst(rst), .start(start3), .base_addr(base3),
    .RAM_R_RE(re3), .RAM_R_A(a3), .RAM_R_D(d3), .weights(w3),
    .busy(busy3), .done(done3), .weights_valid(wv3)
  );

  function automatic logic [WW-1:0] memf(input int mode, input logic [AW-1:0] a);
    case (mode)
      1:       return 24'hFFFFFF;
      2:       return {6'h15, a};
      default: return {6'h00, a};
    endcase
  endfunction

  // RAM models: data for an address appears RD_LAT cycles after it is presented.
  logic [AW-1:0] ad0;
  logic          vd0 = 1'b0;
  always @(posedge clk) begin
    ad0 <= a0;
    vd0 <= re0;
  end
  assign d0 = vd0 ? memf(mode0, ad0) : 24'hBADBAD;

  logic [AW-1:0] ad3 [3];
  logic [2:0]    vd3 = 3'b000;
  always @(posedge clk) begin
    ad3[0] <= a3;
    ad3[1] <= ad3[0];
    ad3[2] <= ad3[1];
    vd3    <= {vd3[1:0], re3};
  end
  assign d3 = vd3[2] ? memf(mode3, ad3[2]) : 24'hBADBAD;

  // Read-address scoreboards.
  always @(negedge clk) begin : mon0
    logic [AW-1:0] e;
    if (re0 === 1'b1) begin
      re_cnt0++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rd_addr0 unexpected read at %h, required no read", a0);
      end else begin
        e = q0.pop_front();
        if (a0 !== e) begin
          errors++;
          $display("FAIL rd_addr0 got %h required %h", a0, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon3
    logic [AW-1:0] e;
    if (re3 === 1'b1) begin
      re_cnt3++;
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rd_addr3 unexpected read at %h, required no read", a3);
      end else begin
        e = q3.pop_front();
        if (a3 !== e) begin
          errors++;
          $display("FAIL rd_addr3 got %h required %h", a3, e);
        end
      end
    end
  end

  // Starts a load on u0 and waits (bounded) until two cycles past done.
  // Extra start pulses are driven during the load at cycles pa and pb.
  task automatic run_load(input logic [AW-1:0] base, input int mode, input int pa,
                          input int pb, output int done_cyc, output int ndone,
                          output bit vld_bad);
    mode0 = mode;
    for (int k = 0; k < NW; k++) q0.push_back(AW'(base + AW'(k)));
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~base;
    done_cyc = -1;
    ndone = 0;
    vld_bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy0 === 1'b1 && wv0 !== 1'b0) vld_bad = 1'b1;
      start = (c == pa || c == pb);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start3 = 1'b0;
    base_addr = 18'h00155; base3 = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (re0 !== 1'b0)  begin errors++; $display("FAIL rst_re got %b required 0", re0); end
    checks++; if (a0 !== '0)     begin errors++; $display("FAIL rst_addr got %h required 0", a0); end
    checks++; if (w0 !== '0)     begin errors++; $display("FAIL rst_weights got %h required 0", w0[WW-1:0]); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done0); end
    checks++; if (wv0 !== 1'b0)  begin errors++; $display("FAIL rst_wvalid got %b required 0", wv0); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0 || re0 !== 1'b0) begin
      errors++; $display("FAIL rst_start_drop busy %b re %b required 0 0", busy0, re0);
    end
  endtask

  task automatic test_basic();
    int dc, nd, rb;
    bit vb;
    logic [WW-1:0] e;
    rb = re_cnt0;
    run_load(18'h00100, 0, -1, -1, dc, nd, vb);
    checks++; if (dc != 67)  begin errors++; $display("FAIL basic_done_cycle got %0d required 67", dc); end
    checks++; if (nd != 1)   begin errors++; $display("FAIL basic_done_count got %0d required 1", nd); end
    checks++; if (vb)        begin errors++; $display("FAIL basic_wvalid_while_busy got 1 required 0"); end
    checks++; if (re_cnt0 - rb != 64 || q0.size() != 0) begin
      errors++; $display("FAIL basic_reads got %0d left %0d required 64 left 0", re_cnt0 - rb, q0.size());
    end
    checks++; if (wv0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL basic_status wv %b busy %b required 1 0", wv0, busy0);
    end
    checks++; if (a0 !== 18'h0013F) begin errors++; $display("FAIL basic_addr_hold got %h required 0013f", a0); end
    checks++; if (w0[NW*WW-1 -: WW] !== 24'h000100) begin
      errors++; $display("FAIL basic_msb_word got %h required 000100", w0[NW*WW-1 -: WW]);
    end
    checks++; if (w0[WW-1:0] !== 24'h00013F) begin
      errors++; $display("FAIL basic_lsb_word got %h required 00013f", w0[WW-1:0]);
    end
    for (int k = 0; k < NW; k++) begin
      e = memf(0, AW'(18'h00100 + AW'(k)));
      checks++;
      if (w0[NW*WW-1-k*WW -: WW] !== e) begin
        errors++; $display("FAIL basic_word%0d got %h required %h", k, w0[NW*WW-1-k*WW -: WW], e);
      end
    end
  endtask

  task automatic test_wrap();
    int dc, nd, rb;
    bit vb;
    logic [WW-1:0] e;
    rb = re_cnt0;
    run_load(18'h3FFF0, 0, -1, -1, dc, nd, vb);
    checks++; if (dc != 67) begin errors++; $display("FAIL wrap_done_cycle got %0d required 67", dc); end
    checks++; if (re_cnt0 - rb != 64 || q0.size() != 0) begin
      errors++; $display("FAIL wrap_reads got %0d left %0d required 64 left 0", re_cnt0 - rb, q0.size());
    end
    checks++; if (w0[NW*WW-1-16*WW -: WW] !== 24'h000000) begin
      errors++; $display("FAIL wrap_word16 got %h required 000000", w0[NW*WW-1-16*WW -: WW]);
    end
    for (int k = 0; k < NW; k++) begin
      e = memf(0, AW'(18'h3FFF0 + AW'(k)));
      checks++;
      if (w0[NW*WW-1-k*WW -: WW] !== e) begin
        errors++; $display("FAIL wrap_word%0d got %h required %h", k, w0[NW*WW-1-k*WW -: WW], e);
      end
    end
  endtask

  task automatic test_restart();
    int dc, nd, rb;
    bit vb;
    logic [WW-1:0] e;
    rb = re_cnt0;
    run_load(18'h00A00, 0, 5, 40, dc, nd, vb);
    checks++; if (dc != 67 || nd != 1) begin
      errors++; $display("FAIL restart_done cycle %0d count %0d required 67 1", dc, nd);
    end
    checks++; if (re_cnt0 - rb != 64 || q0.size() != 0) begin
      errors++; $display("FAIL restart_reads got %0d left %0d required 64 left 0", re_cnt0 - rb, q0.size());
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL restart_idle busy got %b required 0", busy0); end
    for (int k = 0; k < NW; k++) begin
      e = memf(0, AW'(18'h00A00 + AW'(k)));
      checks++;
      if (w0[NW*WW-1-k*WW -: WW] !== e) begin
        errors++; $display("FAIL restart_word%0d got %h required %h", k, w0[NW*WW-1-k*WW -: WW], e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int rb, nd, dc;
    bit vb;
    logic [WW-1:0] e;
    rb = re_cnt0;
    mode0 = 0;
    for (int k = 0; k < NW; k++) q0.push_back(AW'(18'h00200 + AW'(k)));
    base_addr = 18'h00200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) nd++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0 || re0 !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl busy %b re %b required 0 0", busy0, re0);
    end
    checks++; if (w0 !== '0 || wv0 !== 1'b0) begin
      errors++; $display("FAIL midrst_data wlsb %h wv %b required 0 0", w0[WW-1:0], wv0);
    end
    q0.delete();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_no_done got %0d required 0", nd); end
    checks++; if (w0 !== '0) begin errors++; $display("FAIL midrst_late_data got %h required 0", w0[NW*WW-1 -: WW]); end
    checks++; if (re_cnt0 - rb != 30) begin
      errors++; $display("FAIL midrst_reads got %0d required 30", re_cnt0 - rb);
    end
    run_load(18'h00300, 0, -1, -1, dc, nd, vb);
    checks++; if (dc != 67 || wv0 !== 1'b1) begin
      errors++; $display("FAIL midrst_reload done %0d wv %b required 67 1", dc, wv0);
    end
    for (int k = 0; k < NW; k++) begin
      e = memf(0, AW'(18'h00300 + AW'(k)));
      checks++;
      if (w0[NW*WW-1-k*WW -: WW] !== e) begin
        errors++; $display("FAIL midrst_word%0d got %h required %h", k, w0[NW*WW-1-k*WW -: WW], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, rb;
    bit vb;
    logic [WW-1:0] e;
    rb = re_cnt3;
    mode3 = 0;
    for (int k = 0; k < NW; k++) q3.push_back(AW'(18'h01000 + AW'(k)));
    base3 = 18'h01000;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    base3 = 18'h3AAAA;
    dc1 = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin dc1 = c; break; end
    end
    checks++; if (dc1 != 69) begin errors++; $display("FAIL b2b_done1 got %0d required 69", dc1); end
    @(negedge clk);
    checks++; if (wv3 !== 1'b1) begin errors++; $display("FAIL b2b_wvalid_hold got %b required 1", wv3); end
    mode3 = 2;
    for (int k = 0; k < NW; k++) q3.push_back(AW'(18'h02000 + AW'(k)));
    base3 = 18'h02000;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    base3 = 18'h15555;
    dc2 = -1;
    vb = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin dc2 = c; break; end
      if (wv3 !== 1'b0) vb = 1'b1;
    end
    checks++; if (dc2 != 69) begin errors++; $display("FAIL b2b_done2 got %0d required 69", dc2); end
    checks++; if (vb) begin errors++; $display("FAIL b2b_wvalid_low got 1 required 0"); end
    checks++; if (re_cnt3 - rb != 128 || q3.size() != 0) begin
      errors++; $display("FAIL b2b_reads got %0d left %0d required 128 left 0", re_cnt3 - rb, q3.size());
    end
    for (int k = 0; k < NW; k++) begin
      e = memf(2, AW'(18'h02000 + AW'(k)));
      checks++;
      if (w3[NW*WW-1-k*WW -: WW] !== e) begin
        errors++; $display("FAIL b2b_word%0d got %h required %h", k, w3[NW*WW-1-k*WW -: WW], e);
      end
    end
  endtask

`ifdef RD_CODEBOOK_CHKSUM_EN
  task automatic test_chksum();
    int dc, nd;
    bit vb;
    run_load(18'h04000, 1, -1, -1, dc, nd, vb);
    checks++; if (chk0 !== 30'h3FFFFFC0) begin
      errors++; $display("FAIL chksum_all_ones got %h required 3fffffc0", chk0);
    end
    base_addr = 18'h05000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (chk0 !== '0) begin errors++; $display("FAIL chksum_clear got %h required 0", chk0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    base_addr = '0; base3 = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_restart();
    test_mid_reset();
    test_back_to_back();
`ifdef RD_CODEBOOK_CHKSUM_EN
    test_chksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
